laser_safety_ctrl: RTL and testbench

LASER_SAFETY_CTRL -- requirements
Module: laser_safety_ctrl

---
 rtl/laser_safety_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_laser_safety_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/laser_safety_ctrl.sv
// Laser safety controller: arms the laser after a programmable delay once the
// pulse/rate limit registers are consistent, drops the laser gate on the same
// edge a checker fail flag is sampled, latches the fault and runs a fixed-length
// clear handshake with the checker before returning to IDLE.
// Optional feature macro: FAULT_COUNTER_EN adds a saturating 16-bit fault_count.
module laser_safety_ctrl #(
  parameter int unsigned ARM_DELAY    = 16,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        disarm,
  input  logic        fault_clear_req,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        pulse_lower_limit_fail,
  input  logic        pulse_upper_limit_fail,
  input  logic        rate_lower_limit_fail,
  input  logic        rate_upper_limit_fail,
`ifdef FAULT_COUNTER_EN
  output logic [15:0] fault_count,
`endif
  output logic [31:0] pulse_width_lower_limit,
  output logic [31:0] pulse_width_upper_limit,
  output logic [31:0] rate_lower_limit,
  output logic [31:0] rate_upper_limit,
  output logic        clear_fail,
  output logic        laser_enable,
  output logic [2:0]  ctrl_state,
  output logic [3:0]  fault_code,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMING   = 3'd1,
    RUN      = 3'd2,
    FAULT    = 3'd3,
    CLEARING = 3'd4
  } state_e;

  localparam logic [15:0] ARM_LAST = 16'(ARM_DELAY - 1);
  localparam logic [15:0] CLR_LAST = 16'(CLEAR_CYCLES - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0][31:0]  lim_q, lim_d;
  logic [3:0]        fault_code_q, fault_code_d;
  logic              laser_enable_q, laser_enable_d;
  logic              clear_fail_q, clear_fail_d;
  logic              cfg_err_q, cfg_err_d;
  logic              enter_fault;

  logic [3:0] fail_vec;
  logic       any_fail;
  logic       lim_ok;

  assign fail_vec = {rate_upper_limit_fail, rate_lower_limit_fail,
                     pulse_upper_limit_fail, pulse_lower_limit_fail};
  assign any_fail = |fail_vec;
  // Zero upper limits (the reset value) are never valid, so a fresh part
  // cannot arm until software has programmed the limits.
  assign lim_ok = (lim_q[0] <= lim_q[1]) && (lim_q[2] <= lim_q[3]) &&
                  (lim_q[1] != 32'd0) && (lim_q[3] != 32'd0);

  // Next-state, limit-register and output-register logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lim_d        = lim_q;
    fault_code_d = fault_code_q;
    cfg_err_d    = 1'b0;
    enter_fault  = 1'b0;

    // Limits may only change while the laser cannot be running.
    if (cfg_we) begin
      if (state_q == IDLE) lim_d[cfg_addr] = cfg_wdata;
      else                 cfg_err_d = 1'b1;
    end

    case (state_q)
      // A fail flag in IDLE only blocks arming; nothing is running to stop.
      IDLE: begin
        if (!any_fail && !disarm && arm) begin
          if (lim_ok) begin
            state_d = ARMING;
            cnt_d   = 16'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ARMING: begin
        if (any_fail)              enter_fault = 1'b1;
        else if (disarm)           state_d = IDLE;
        else if (cnt_q == ARM_LAST) state_d = RUN;
        else                       cnt_d = cnt_q + 16'd1;
      end
      RUN: begin
        if (any_fail)    enter_fault = 1'b1;
        else if (disarm) state_d = IDLE;
      end
      FAULT: begin
        if (fault_clear_req) begin
          state_d = CLEARING;
          cnt_d   = 16'd0;
        end
      end
      // Nothing but reset cuts the clear pulse short; flags are judged at the end.
      CLEARING: begin
        if (cnt_q == CLR_LAST) begin
          if (any_fail) enter_fault = 1'b1;
          else          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_fault) begin
      state_d      = FAULT;
      fault_code_d = fail_vec;
      cnt_d        = 16'd0;
    end

    // Decoded from the next state so the gate drops on the edge that sees the flag.
    laser_enable_d = (state_d == RUN);
    clear_fail_d   = (state_d == CLEARING);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      lim_q          <= '0;
      fault_code_q   <= 4'd0;
      laser_enable_q <= 1'b0;
      clear_fail_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lim_q          <= lim_d;
      fault_code_q   <= fault_code_d;
      laser_enable_q <= laser_enable_d;
      clear_fail_q   <= clear_fail_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

`ifdef FAULT_COUNTER_EN
  logic [15:0] fault_cnt_q, fault_cnt_d;

  // Saturating count of FAULT entries.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (enter_fault && (fault_cnt_q != 16'hFFFF)) fault_cnt_d = fault_cnt_q + 16'd1;
  end

  // Fault counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) fault_cnt_q <= 16'd0;
    else     fault_cnt_q <= fault_cnt_d;
  end

  assign fault_count = fault_cnt_q;
`endif

  assign pulse_width_lower_limit = lim_q[0];
  assign pulse_width_upper_limit = lim_q[1];
  assign rate_lower_limit        = lim_q[2];
  assign rate_upper_limit        = lim_q[3];
  assign clear_fail              = clear_fail_q;
  assign laser_enable            = laser_enable_q;
  assign ctrl_state              = state_q;
  assign fault_code              = fault_code_q;
  assign cfg_err                 = cfg_err_q;

endmodule

// File: tb/tb_laser_safety_ctrl.sv
// Directed bench for laser_safety_ctrl with default parameters
// (ARM_DELAY=16, CLEAR_CYCLES=4).
module tb_laser_safety_ctrl;

  logic        clk = 1'b0;
  logic        rst, arm, disarm, fault_clear_req, cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        plf, puf, rlf, ruf;
  logic [31:0] pwl, pwu, rl, ru;
  logic        clear_fail, laser_enable, cfg_err;
  logic [2:0]  ctrl_state;
  logic [3:0]  fault_code;
`ifdef FAULT_COUNTER_EN
  logic [15:0] fault_count;
`endif

  int vectors = 0;
  int errs    = 0;

  laser_safety_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
    .fault_clear_req(fault_clear_req), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .pulse_lower_limit_fail(plf), .pulse_upper_limit_fail(puf),
    .rate_lower_limit_fail(rlf), .rate_upper_limit_fail(ruf),
`ifdef FAULT_COUNTER_EN
    .fault_count(fault_count),
`endif
    .pulse_width_lower_limit(pwl), .pulse_width_upper_limit(pwu),
    .rate_lower_limit(rl), .rate_upper_limit(ru),
    .clear_fail(clear_fail), .laser_enable(laser_enable),
    .ctrl_state(ctrl_state), .fault_code(fault_code), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 0; disarm = 0; fault_clear_req = 0; cfg_we = 0;
    cfg_addr = 0; cfg_wdata = 0; plf = 0; puf = 0; rlf = 0; ruf = 0;
    #2;
    tick(); tick();
    check("rst_state", 32'(ctrl_state), 0);
    check("rst_limits", pwl | pwu | rl | ru, 0);
    check("rst_le", 32'(laser_enable), 0);
    check("rst_cf", 32'(clear_fail), 0);
    check("rst_fc", 32'(fault_code), 0);
    check("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;

    // Arm with zero limits is rejected
    arm = 1; tick();
    check("noarm_err", 32'(cfg_err), 1);
    check("noarm_state", 32'(ctrl_state), 0);
    check("noarm_le", 32'(laser_enable), 0);
    arm = 0; tick();
    check("noarm_err_clr", 32'(cfg_err), 0);

    // Program limits 10/100/200/1000
    wr(2'd0, 32'd10); wr(2'd1, 32'd100); wr(2'd2, 32'd200); wr(2'd3, 32'd1000);
    check("lim_pwl", pwl, 10);
    check("lim_pwu", pwu, 100);
    check("lim_rl", rl, 200);
    check("lim_ru", ru, 1000);
    check("lim_err", 32'(cfg_err), 0);

    // Arm: 16 cycles in ARMING then RUN
    arm = 1; tick(); arm = 0;
    for (int i = 0; i < 16; i++) begin
      check("arming_state", 32'(ctrl_state), 1);
      check("arming_le", 32'(laser_enable), 0);
      tick();
    end
    check("run_state", 32'(ctrl_state), 2);
    check("run_le", 32'(laser_enable), 1);

    // Write in RUN is rejected
    wr(2'd0, 32'd5);
    check("runwr_err", 32'(cfg_err), 1);
    check("runwr_pwl", pwl, 10);
    check("runwr_state", 32'(ctrl_state), 2);
    tick();
    check("runwr_err_clr", 32'(cfg_err), 0);

    // One-cycle rate_upper fail in RUN
    ruf = 1; tick(); ruf = 0;
    check("flt_le", 32'(laser_enable), 0);
    check("flt_state", 32'(ctrl_state), 3);
    check("flt_code", 32'(fault_code), 4'b1000);
    arm = 1; tick(); arm = 0;
    check("flt_arm_ign", 32'(ctrl_state), 3);
    disarm = 1; tick(); disarm = 0;
    check("flt_disarm_ign", 32'(ctrl_state), 3);

    // Clear with flags low; arm during CLEARING must not shorten the pulse
    fault_clear_req = 1; tick(); fault_clear_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) arm = 1;
      if (i == 2) arm = 0;
      check("clr_cf", 32'(clear_fail), 1);
      check("clr_state", 32'(ctrl_state), 4);
      tick();
    end
    check("clr_done_state", 32'(ctrl_state), 0);
    check("clr_done_cf", 32'(clear_fail), 0);
    check("clr_code_hold", 32'(fault_code), 4'b1000);

    // Arm and pulse_lower fail together during ARMING -> FAULT
    arm = 1; tick();
    check("arm2_state", 32'(ctrl_state), 1);
    plf = 1; tick(); plf = 0; arm = 0;
    check("armflt_state", 32'(ctrl_state), 3);
    check("armflt_code", 32'(fault_code), 4'b0001);
    check("armflt_le", 32'(laser_enable), 0);

    // Clear with rate_lower still high -> back to FAULT, code recaptured
    fault_clear_req = 1; tick(); fault_clear_req = 0;
    rlf = 1;
    for (int i = 0; i < 4; i++) begin
      check("reclr_cf", 32'(clear_fail), 1);
      tick();
    end
    check("reflt_state", 32'(ctrl_state), 3);
    check("reflt_code", 32'(fault_code), 4'b0100);
    check("reflt_cf", 32'(clear_fail), 0);
    rlf = 0;

    // Reset in the middle of CLEARING
    fault_clear_req = 1; tick(); fault_clear_req = 0;
    check("rstclr_pre", 32'(ctrl_state), 4);
    tick();
    rst = 1; tick(); rst = 0;
    check("rstclr_state", 32'(ctrl_state), 0);
    check("rstclr_cf", 32'(clear_fail), 0);
    check("rstclr_fc", 32'(fault_code), 0);
    check("rstclr_lim", pwl | pwu | rl | ru, 0);

    // After reset arm is rejected again; then inconsistent limits are rejected
    arm = 1; tick(); arm = 0;
    check("rearm_err", 32'(cfg_err), 1);
    check("rearm_state", 32'(ctrl_state), 0);
    wr(2'd0, 32'd200); wr(2'd1, 32'd100); wr(2'd2, 32'd1); wr(2'd3, 32'd5);
    arm = 1; tick(); arm = 0;
    check("badlim_err", 32'(cfg_err), 1);
    check("badlim_state", 32'(ctrl_state), 0);
    wr(2'd1, 32'd300);
    arm = 1; tick(); arm = 0;
    check("goodlim_state", 32'(ctrl_state), 1);
    check("goodlim_err", 32'(cfg_err), 0);
    disarm = 1; tick(); disarm = 0;
    check("disarm_state", 32'(ctrl_state), 0);
    check("disarm_le", 32'(laser_enable), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
